// File: rtl/imem_boot_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    ImemClear = 2'b00,
    ImemLoad  = 2'b01,
    ImemRun   = 2'b10
  } imem_state_e;

endpackage

// File: rtl/imem_boot_loader_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
module imem_boot_loader_array #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  // No reset: the loader's CLEAR phase initialises every word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-side responder: clears storage, loads a program over valid/ready
// while holding the CPU in reset, then serves zero-latency fetches.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter logic [31:0] NOP_INSTR  = NopInstr
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [31:0]           ld_data_i,
  input  logic                  ld_last_i,
  input  logic                  ld_restart_i,
  input  logic [31:0]           pc_i,
  output logic [31:0]           instr_o,
  output logic                  cpu_rst_o,
  output logic                  load_done_o,
  output logic [DEPTH_LOG2:0]   load_count_o,
  output logic                  err_overflow_o
);

  localparam logic [DEPTH_LOG2-1:0] MaxAddr  = {DEPTH_LOG2{1'b1}};
  localparam logic [DEPTH_LOG2:0]   DepthCnt = {1'b1, {DEPTH_LOG2{1'b0}}};

  imem_state_e             state_q, state_d;
  logic [DEPTH_LOG2-1:0]   clear_ptr_q, clear_ptr_d;
  logic [DEPTH_LOG2:0]     wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]     load_count_q, load_count_d;
  logic                    err_q, err_d;
  logic                    cpu_rst_q;

  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [31:0]             mem_wdata;
  logic [31:0]             mem_rdata;
  logic                    xfer;
  logic                    pc_in_range;
  logic                    unused_pc;

  assign ld_ready_o = (state_q == ImemLoad);
  assign xfer       = ld_valid_i & ld_ready_o;

  always_comb begin
    state_d      = state_q;
    clear_ptr_d  = clear_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    load_count_d = load_count_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = NOP_INSTR;
    case (state_q)
      ImemClear: begin
        mem_we       = 1'b1;
        mem_waddr    = clear_ptr_q;
        mem_wdata    = NOP_INSTR;
        clear_ptr_d  = clear_ptr_q + DEPTH_LOG2'(1);
        wr_ptr_d     = '0;
        load_count_d = '0;
        if (clear_ptr_q == MaxAddr) begin
          state_d = ImemLoad;
        end
      end
      ImemLoad: begin
        if (xfer) begin
          // Words beyond capacity are dropped; the count stays saturated.
          if (wr_ptr_q < DepthCnt) begin
            mem_we       = 1'b1;
            mem_waddr    = wr_ptr_q[DEPTH_LOG2-1:0];
            mem_wdata    = ld_data_i;
            wr_ptr_d     = wr_ptr_q + (DEPTH_LOG2 + 1)'(1);
            load_count_d = load_count_q + (DEPTH_LOG2 + 1)'(1);
          end else begin
            err_d = 1'b1;
          end
          if (ld_last_i) begin
            state_d = ImemRun;
          end
        end
      end
      ImemRun: begin
        if (ld_restart_i) begin
          state_d      = ImemClear;
          clear_ptr_d  = '0;
          wr_ptr_d     = '0;
          load_count_d = '0;
          err_d        = 1'b0;
        end
      end
      default: begin
        state_d      = ImemClear;
        clear_ptr_d  = '0;
        wr_ptr_d     = '0;
        load_count_d = '0;
        err_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ImemClear;
      clear_ptr_q  <= '0;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      err_q        <= 1'b0;
      cpu_rst_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      load_count_q <= load_count_d;
      err_q        <= err_d;
      // Released on the same edge that enters RUN, so the CPU fetches PC 0 next.
      cpu_rst_q    <= (state_d != ImemRun);
    end
  end

  imem_boot_loader_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .raddr_i(pc_i[DEPTH_LOG2+1:2]),
    .rdata_o(mem_rdata)
  );

  assign pc_in_range = ~|pc_i[31:DEPTH_LOG2+2];
  assign unused_pc   = ^pc_i[1:0];

  assign instr_o        = ((state_q == ImemRun) && pc_in_range) ? mem_rdata : NOP_INSTR;
  assign cpu_rst_o      = cpu_rst_q;
  assign load_done_o    = (state_q == ImemRun);
  assign load_count_o   = load_count_q;
  assign err_overflow_o = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader with an 8-word memory.
module tb_imem_boot_loader;

  localparam int unsigned DL    = 3;
  localparam int unsigned Depth = 8;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic          clk;
  logic          rst_ni;
  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_restart;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic          cpu_rst;
  logic          load_done;
  logic [DL:0]   load_count;
  logic          err_overflow;

  int            n_checks;
  int            n_errors;
  logic [31:0]   exp_q[$];
  logic [31:0]   model[Depth];
  int            model_cnt;
  bit            model_ovf;

  imem_boot_loader #(
    .DEPTH_LOG2(DL),
    .NOP_INSTR (Nop)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .ld_valid_i    (ld_valid),
    .ld_ready_o    (ld_ready),
    .ld_data_i     (ld_data),
    .ld_last_i     (ld_last),
    .ld_restart_i  (ld_restart),
    .pc_i          (pc),
    .instr_o       (instr),
    .cpu_rst_o     (cpu_rst),
    .load_done_o   (load_done),
    .load_count_o  (load_count),
    .err_overflow_o(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) model[i] = Nop;
    model_cnt = 0;
    model_ovf = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input int gap);
    ld_valid = 1'b0;
    repeat (gap) @(negedge clk);
    if (last) check_val("cpu_rst_before_last", 32'(cpu_rst), 32'd1);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(negedge clk);
    if (model_cnt < Depth) begin
      model[model_cnt] = d;
      model_cnt++;
    end else begin
      model_ovf = 1'b1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (last) begin
      check_val("cpu_rst_after_last", 32'(cpu_rst), 32'd0);
      check_val("load_done", 32'(load_done), 32'd1);
      check_val("ld_ready_run", 32'(ld_ready), 32'd0);
    end
  endtask

  task automatic wait_clear();
    int cycles;
    cycles = 0;
    while (!ld_ready && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check_val("clear_cycles", 32'(cycles), 32'(Depth));
    pc = 32'h0;
    #2;
    check_val("instr_in_load", instr, Nop);
    @(negedge clk);
  endtask

  task automatic restart();
    ld_restart = 1'b1;
    @(negedge clk);
    ld_restart = 1'b0;
    check_val("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check_val("restart_load_done", 32'(load_done), 32'd0);
    check_val("restart_count", 32'(load_count), 32'd0);
    check_val("restart_err", 32'(err_overflow), 32'd0);
    wait_clear();
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    exp_q.push_back(exp);
    #2;
    check_val($sformatf("fetch_%08h", addr), instr, exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic check_program();
    check_val("load_count", 32'(load_count), 32'(model_cnt));
    check_val("err_overflow", 32'(err_overflow), 32'(model_ovf));
    for (int i = 0; i < Depth; i++) begin
      // Low pc bits vary to confirm they are ignored.
      fetch(32'(i * 4 + (i % 4)), model[i]);
    end
    fetch(32'h20, Nop);
    fetch(32'hFFFF_FFF0, Nop);
  endtask

  logic [31:0] prog1 [8];

  initial begin
    prog1 = '{32'h00100093, 32'h00200113, 32'h002081b3, 32'h00c0026f,
              32'h00500293, 32'h00600313, 32'h006283b3, 32'h00400413};
    n_checks   = 0;
    n_errors   = 0;
    rst_ni     = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    ld_restart = 1'b0;
    pc         = '0;
    repeat (3) @(negedge clk);
    check_val("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_val("rst_ld_ready", 32'(ld_ready), 32'd0);
    check_val("rst_load_done", 32'(load_done), 32'd0);
    check_val("rst_count", 32'(load_count), 32'd0);
    check_val("rst_err", 32'(err_overflow), 32'd0);
    check_val("rst_instr", instr, Nop);
    rst_ni = 1'b1;
    wait_clear();

    // Full 8-word program.
    model_reset();
    for (int i = 0; i < 8; i++) send_word(prog1[i], (i == 7), 0);
    check_program();
    fetch(32'h0C, 32'h00c0026f);
    fetch(32'h20, Nop);

    // Short 3-word load.
    restart();
    model_reset();
    for (int i = 0; i < 3; i++) send_word(prog1[i], (i == 2), 0);
    check_program();
    fetch(32'h08, 32'h002081b3);
    fetch(32'h1C, Nop);

    // Overflowing 10-word load.
    restart();
    model_reset();
    for (int i = 0; i < 10; i++) send_word(32'h1000_0000 + 32'(i), (i == 9), 0);
    check_program();
    check_val("ovf_flag", 32'(err_overflow), 32'd1);
    check_val("ovf_count", 32'(load_count), 32'd8);

    // Restart clears the overflow flag; single-word load.
    restart();
    model_reset();
    send_word(32'h00a00093, 1'b1, 0);
    check_program();
    fetch(32'h00, 32'h00a00093);
    fetch(32'h04, Nop);

    // Random gaps between words.
    restart();
    model_reset();
    for (int i = 0; i < 8; i++) send_word($urandom, (i == 7), int'($urandom_range(0, 3)));
    check_program();

    // Reset mid-load, then a fresh 2-word load.
    restart();
    for (int i = 0; i < 4; i++) send_word(prog1[i], 1'b0, 0);
    ld_valid = 1'b1;
    ld_data  = prog1[4];
    #2;
    rst_ni = 1'b0;
    #1;
    check_val("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_val("midrst_ld_ready", 32'(ld_ready), 32'd0);
    check_val("midrst_count", 32'(load_count), 32'd0);
    ld_valid = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    wait_clear();
    model_reset();
    send_word(32'h00b00093, 1'b0, 0);
    send_word(32'h00c00113, 1'b1, 0);
    check_program();
    fetch(32'h08, Nop);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Instruction-side responder for PipelineCPU: the memory at the other end of the CPU fetch interface (PC_out -> instr_in).
- Replaces the bench-only behavioural instruction ROM with synthesizable RTL.
- After reset it clears its storage to NOP, accepts a program over a valid/ready load stream while holding the CPU in reset, then serves combinational fetches.
- Supports reloading at runtime.

Parameters:
- DEPTH_LOG2, 6, log2 of the word count; DEPTH = 2**DEPTH_LOG2 words.
- NOP_INSTR, 32'h00000013, word returned for cleared, out-of-range or not-running fetches.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ld_valid  input  1  load word present.
- ld_ready  output  1  loader can accept a word.
- ld_data  input  32  instruction word to store.
- ld_last  input  1  qualifies the final word of a load.
- ld_restart  input  1  single-cycle request to reload; honoured only in RUN.
- pc  input  32  fetch address, wired from CPU PC_out.
- instr  output  32  fetched instruction, wired to CPU instr_in.
- cpu_rst  output  1  active-high hold for the CPU rst input.
- load_done  output  1  high in RUN.
- load_count  output  DEPTH_LOG2+1  words stored by the last or current load; saturates at DEPTH.
- err_overflow  output  1  sticky: a load sent more than DEPTH words.

Behaviour:
- States are CLEAR, LOAD and RUN. Encoding is 2 bits; the fourth code recovers to CLEAR.
- Reset (rst=0, asynchronous) sets:
  - state=CLEAR, clear_ptr=0, wr_ptr=0, load_count=0;
  - err_overflow=0, cpu_rst=1, load_done=0, ld_ready=0.
  - Memory contents are not reset; CLEAR overwrites them.
- CLEAR:
  - Writes NOP_INSTR to mem[clear_ptr] each cycle and increments clear_ptr.
  - After writing DEPTH-1 the state moves to LOAD, so CLEAR lasts exactly DEPTH cycles.
  - ld_ready=0 throughout.
- LOAD:
  - ld_ready=1. A transfer happens when ld_valid & ld_ready.
  - On a transfer with wr_ptr<DEPTH: mem[wr_ptr]<=ld_data, wr_ptr++, load_count++.
  - On a transfer with wr_ptr==DEPTH: the word is discarded, err_overflow<=1, and load_count holds at DEPTH.
  - A transfer carrying ld_last moves the state to RUN on the next edge; that word is stored under the same rules.
  - ld_last without ld_valid is ignored.
  - A load with zero words is impossible; the first accepted word may carry ld_last.
- RUN:
  - ld_ready=0 and load_done=1.
  - cpu_rst is registered: state != RUN. It falls on the same edge the state enters RUN.
  - A CPU released by that edge fetches PC 0 on its first clock.
- Fetch (combinational read, zero latency, as the CPU requires):
  - instr = mem[pc[DEPTH_LOG2+1:2]] when state==RUN and pc[31:2] < DEPTH.
  - Otherwise instr = NOP_INSTR.
  - pc[1:0] is ignored.
- ld_restart in RUN:
  - The next edge sets state=CLEAR, clear_ptr=0, wr_ptr=0, load_count=0, err_overflow=0, cpu_rst=1, load_done=0.
  - ld_restart in CLEAR or LOAD is ignored.
- Simultaneous ld_restart and any ld transfer: impossible, since ld_ready=0 in RUN.
- Reset mid-LOAD or mid-CLEAR: an immediate return to CLEAR with the reset values above. The partial program is discarded by the subsequent clear.
- Unstored words after a short load read as NOP_INSTR, because CLEAR precedes every LOAD.

Decomposition:
- Shared package/header (alongside ctrl_encode_def.v):
  - NOP_INSTR constant;
  - state encodings IMEM_CLEAR / IMEM_LOAD / IMEM_RUN.
- One sub-module, imem_array: DEPTH x 32 storage with one synchronous write port and one asynchronous read port. It holds no control logic.
- The FSM, pointers and fetch mux live in imem_boot_loader.

Test Plan:
All scenarios use DEPTH_LOG2=3 unless noted.
1. Release rst, wait 8 cycles, stream the 8-word program 00100093, 00200113, 002081b3, 00c0026f, 00500293, 00600313, 006283b3, 00400413 with ld_last on the 8th word.
   -> cpu_rst falls after the last transfer; load_count=8; pc=0x0C gives 00c0026f; pc=0x20 gives 00000013.
   -> With PipelineCPU attached: x3=3, x4=0x10, x5=x6=0, x8=4.
2. Load 3 words with ld_last on the 3rd.
   -> load_count=3; pc=0x08 gives 002081b3; pc=0x0C and pc=0x1C give 00000013; err_overflow=0.
3. Load 10 words with ld_last on the 10th.
   -> err_overflow=1, load_count=8; words 9 and 10 are dropped; pc=0x00 gives the first word.
4. Hold ld_valid low for random gaps between words.
   -> Only valid&ready cycles advance wr_ptr; the stored contents match the sent order exactly.
5. Pull rst low after 4 of 8 words.
   -> cpu_rst=1, ld_ready=0 immediately; after release, 8 CLEAR cycles occur; a fresh 2-word load leaves pc=0x08 giving 00000013.
6. In RUN, pulse ld_restart, then load 00a00093 alone (with ld_last).
   -> cpu_rst=1 on the next edge, then a full CLEAR; pc=0x00 gives 00a00093; pc=0x04 gives 00000013; err_overflow is cleared.
